// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store memory controller (store/load
// select fields, FSM states, access sizes and byte-enable base patterns).
package lsu_pkg;

   localparam logic [1:0] WSEL_WORD  = 2'b00;
   localparam logic [1:0] WSEL_BYTE  = 2'b01;
   localparam logic [1:0] WSEL_WORD2 = 2'b10;
   localparam logic [1:0] WSEL_HALF  = 2'b11;

   localparam logic [2:0] RSEL_WORD  = 3'b000;
   localparam logic [2:0] RSEL_BYTE  = 3'b001;
   localparam logic [2:0] RSEL_HALF  = 3'b010;
   localparam logic [2:0] RSEL_BYTEU = 3'b011;
   localparam logic [2:0] RSEL_HALFU = 3'b100;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   typedef enum logic [1:0] {ST_IDLE, ST_REQ1, ST_REQ2, ST_RESP} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   function automatic size_t access_size(input logic rw, input logic [1:0] wsel,
                                         input logic [2:0] rsel);
      size_t sz;
      sz = SZ_WORD;
      if (rw) begin
         case (wsel)
            WSEL_BYTE:             sz = SZ_BYTE;
            WSEL_HALF:             sz = SZ_HALF;
            WSEL_WORD, WSEL_WORD2: sz = SZ_WORD;
            default:               sz = SZ_WORD;
         endcase
      end else begin
         case (rsel)
            RSEL_BYTE, RSEL_BYTEU: sz = SZ_BYTE;
            RSEL_HALF, RSEL_HALFU: sz = SZ_HALF;
            RSEL_WORD:             sz = SZ_WORD;
            default:               sz = SZ_WORD;
         endcase
      end
      return sz;
   endfunction

   function automatic logic is_misaligned(input size_t sz, input logic [1:0] off);
      return ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
   endfunction

   // Accesses whose bytes spill past lane 3 into the next word.
   function automatic logic crosses_word(input size_t sz, input logic [1:0] off);
      return ((sz == SZ_HALF) && (off == 2'b11)) || ((sz == SZ_WORD) && (off != 2'b00));
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane steering for stores and byte-select plus
// sign/zero extension for loads, working on a two-word window.
module lsu_align
   import lsu_pkg::*;
(
   input  size_t       size,
   input  logic [1:0]  off,
   input  logic [2:0]  rsel,
   input  logic        second,
   input  logic [31:0] wdata,
   input  logic [63:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [3:0]  be_base;
   logic [7:0]  be_wide;
   logic [31:0] wd_rep;
   logic [63:0] wd_wide;
   logic [31:0] r_word;

   always_comb begin
      case (size)
         SZ_BYTE: begin be_base = BE_BYTE; wd_rep = {4{wdata[7:0]}};  end
         SZ_HALF: begin be_base = BE_HALF; wd_rep = {2{wdata[15:0]}}; end
         default: begin be_base = BE_WORD; wd_rep = wdata;            end
      endcase
      // Shifting into an 8-lane window gives the upper-word lanes of a split access for free.
      be_wide = {4'b0000, be_base} << off;
      wd_wide = {32'd0, wdata} << {off, 3'b000};
      if (second) begin
         be         = be_wide[7:4];
         wdata_lane = wd_wide[63:32];
      end else if (is_misaligned(size, off)) begin
         be         = be_wide[3:0];
         wdata_lane = wd_wide[31:0];
      end else begin
         be         = be_wide[3:0];
         wdata_lane = wd_rep;
      end
   end

   always_comb begin
      r_word = 32'(rword >> {off, 3'b000});
      case (rsel)
         RSEL_BYTE:  rdata_ext = {{24{r_word[7]}}, r_word[7:0]};
         RSEL_HALF:  rdata_ext = {{16{r_word[15]}}, r_word[15:0]};
         RSEL_BYTEU: rdata_ext = {24'd0, r_word[7:0]};
         RSEL_HALFU: rdata_ext = {16'd0, r_word[15:0]};
         default:    rdata_ext = r_word;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: one data-memory access per start pulse over a req/ack word bus.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses instead of aborting them.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        mem_rw,
   input  logic [1:0]  data_w_sel,
   input  logic [2:0]  data_r_sel,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   state_t      state, state_nx;
   logic        rw_q;
   size_t       size_q;
   logic [2:0]  rsel_q;
   logic [31:0] addr_q, wdata_q, lo_q, rdata_q;
   logic        err_q;
   logic [15:0] cnt;

   size_t       size_in;
   logic        abort_in, in_req, need_second, timed_out;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata, load_ext;
   logic [63:0] load_word;

   assign size_in     = access_size(mem_rw, data_w_sel, data_r_sel);
   assign abort_in    = !SPLIT && is_misaligned(size_in, addr[1:0]);
   assign in_req      = (state == ST_REQ1) || (state == ST_REQ2);
   assign need_second = SPLIT && crosses_word(size_q, addr_q[1:0]);
   assign timed_out   = (TIMEOUT != 0) && (cnt == 16'(TIMEOUT));
   // The first word of a split read sits in the low half of the merge window.
   assign load_word   = (state == ST_REQ2) ? {mem_rdata, lo_q} : {32'd0, mem_rdata};

   lsu_align u_align (
      .size       (size_q),
      .off        (addr_q[1:0]),
      .rsel       (rsel_q),
      .second     (state == ST_REQ2),
      .wdata      (wdata_q),
      .rword      (load_word),
      .be         (lane_be),
      .wdata_lane (lane_wdata),
      .rdata_ext  (load_ext)
   );

   always_comb begin
      state_nx  = state;
      busy      = (state != ST_IDLE);
      done      = (state == ST_RESP);
      err       = done && err_q;
      rdata     = done ? rdata_q : 32'd0;
      mem_req   = in_req;
      mem_we    = in_req && rw_q;
      mem_addr  = 32'd0;
      mem_be    = 4'd0;
      mem_wdata = 32'd0;
      if (in_req) begin
         mem_addr  = {addr_q[31:2], 2'b00} + ((state == ST_REQ2) ? 32'd4 : 32'd0);
         mem_be    = lane_be;
         mem_wdata = rw_q ? lane_wdata : 32'd0;
      end
      case (state)
         ST_IDLE: if (start) state_nx = abort_in ? ST_RESP : ST_REQ1;
         ST_REQ1: begin
            if (mem_ack)        state_nx = need_second ? ST_REQ2 : ST_RESP;
            else if (timed_out) state_nx = ST_RESP;
         end
         ST_REQ2: if (mem_ack || timed_out) state_nx = ST_RESP;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         rw_q    <= 1'b0;
         size_q  <= SZ_WORD;
         rsel_q  <= 3'd0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         lo_q    <= 32'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
         cnt     <= 16'd0;
      end else begin
         state <= state_nx;
         case (state)
            ST_IDLE: if (start) begin
               rw_q    <= mem_rw;
               size_q  <= size_in;
               rsel_q  <= data_r_sel;
               addr_q  <= addr;
               wdata_q <= wdata;
               err_q   <= abort_in;
               rdata_q <= 32'd0;
               cnt     <= 16'd0;
            end
            ST_REQ1, ST_REQ2: begin
               if (mem_ack) begin
                  cnt <= 16'd0;
                  if ((state == ST_REQ1) && need_second) lo_q <= mem_rdata;
                  else rdata_q <= rw_q ? 32'd0 : load_ext;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  rdata_q <= 32'd0;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
